// File: rtl/data_selector_arbiter.sv
// Two-requester arbiter for the 2:1 data_selector: drives sel so that A or B owns q.
// Ties go round-robin, hold time is bounded, and each handoff inserts one dead GAP cycle.
// valid marks the cycles in which q carries the current owner's data.
// Optional macro FIXED_PRIO_EN: every tie goes to A, and only B can be preempted by the hold limit.
`timescale 1ns/1ps

module data_selector_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b,
  output logic sel,
  output logic valid
);

  localparam int unsigned HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] OWN_A = 2'd1;
  localparam logic [1:0] OWN_B = 2'd2;
  localparam logic [1:0] GAP   = 2'd3;

  logic [1:0]    state, state_nxt;
  logic [1:0]    arb_state;
  logic          last_b, last_b_nxt;   // 1: B was the most recent owner
  logic [HW-1:0] hcnt, hcnt_nxt;
  logic          sel_nxt;
  logic          tie_to_b;
  logic          preempt_a;
  logic          preempt_b;

`ifdef FIXED_PRIO_EN
  assign tie_to_b  = 1'b0;
  assign preempt_a = 1'b0;
`else
  assign tie_to_b  = ~last_b;
  assign preempt_a = (hcnt == HOLD_MAX) && req_b;
`endif
  assign preempt_b = (hcnt == HOLD_MAX) && req_a;

  // Arbitration outcome used when leaving IDLE or GAP
  always_comb begin
    arb_state = IDLE;
    if (req_a && req_b) begin
      arb_state = tie_to_b ? OWN_B : OWN_A;
    end else if (req_a) begin
      arb_state = OWN_A;
    end else if (req_b) begin
      arb_state = OWN_B;
    end
  end

  // Next-state, hold counter, fairness pointer and select
  always_comb begin
    state_nxt  = state;
    hcnt_nxt   = hcnt;
    last_b_nxt = last_b;
    sel_nxt    = sel;
    case (state)
      IDLE, GAP: begin
        state_nxt = arb_state;
        if (arb_state == OWN_A) begin
          last_b_nxt = 1'b0;
          hcnt_nxt   = HW'(1);
          sel_nxt    = 1'b0;
        end else if (arb_state == OWN_B) begin
          last_b_nxt = 1'b1;
          hcnt_nxt   = HW'(1);
          sel_nxt    = 1'b1;
        end
      end
      OWN_A: begin
        // A release takes priority over preemption; both lead to the same target
        if (!req_a) begin
          state_nxt = req_b ? GAP : IDLE;
        end else if (preempt_a) begin
          state_nxt = GAP;
        end else if (hcnt != HOLD_MAX) begin
          hcnt_nxt = hcnt + HW'(1);
        end
      end
      OWN_B: begin
        if (!req_b) begin
          state_nxt = req_a ? GAP : IDLE;
        end else if (preempt_b) begin
          state_nxt = GAP;
        end else if (hcnt != HOLD_MAX) begin
          hcnt_nxt = hcnt + HW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register and registered outputs decoded from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      last_b <= 1'b1;
      hcnt   <= '0;
      sel    <= 1'b0;
      gnt_a  <= 1'b0;
      gnt_b  <= 1'b0;
      valid  <= 1'b0;
    end else begin
      state  <= state_nxt;
      last_b <= last_b_nxt;
      hcnt   <= hcnt_nxt;
      sel    <= sel_nxt;
      gnt_a  <= (state_nxt == OWN_A);
      gnt_b  <= (state_nxt == OWN_B);
      valid  <= (state_nxt == OWN_A) || (state_nxt == OWN_B);
    end
  end

endmodule

// File: tb/tb_data_selector_arbiter.sv
// Self-checking bench for data_selector_arbiter: table of single-cycle vectors
// plus hand-written multi-cycle sequences, all checked through a scoreboard queue.
`timescale 1ns/1ps

module tb_data_selector_arbiter;

  logic clk;
  logic rst;
  logic req_a;
  logic req_b;
  logic gnt_a;
  logic gnt_b;
  logic sel;
  logic valid;

`ifdef FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  // Expected {gnt_a, gnt_b, sel, valid}
  localparam logic [3:0] OA = 4'b1001;
  localparam logic [3:0] OB = 4'b0111;
  localparam logic [3:0] Z0 = 4'b0000;
  localparam logic [3:0] Z1 = 4'b0010;

  typedef struct {
    logic       rst;
    logic       ra;
    logic       rb;
    logic [3:0] exp;
    string      tag;
  } vec_t;

  typedef struct {
    logic [3:0] exp;
    string      tag;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];
  int   tests  = 0;
  int   failed = 0;

  data_selector_arbiter #(.MAX_HOLD(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .req_a (req_a),
    .req_b (req_b),
    .gnt_a (gnt_a),
    .gnt_b (gnt_b),
    .sel   (sel),
    .valid (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop if the run ever stalls
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion before 200000ns");
    $fatal(1);
  end

  task automatic addv(input logic r, input logic a, input logic b,
                      input logic [3:0] e, input string t);
    vec_t v;
    v.rst = r; v.ra = a; v.rb = b; v.exp = e; v.tag = t;
    vecs.push_back(v);
  endtask

  task automatic check_out();
    sb_t        s;
    logic [3:0] got;
    if (sb.size() == 0) begin
      tests++;
      failed++;
      $display("FAIL scoreboard: got empty queue, required one pending entry");
    end else begin
      s   = sb.pop_front();
      got = {gnt_a, gnt_b, sel, valid};
      tests++;
      if (got !== s.exp) begin
        failed++;
        $display("FAIL %s: got {gnt_a,gnt_b,sel,valid}=%b, required %b", s.tag, got, s.exp);
      end
      tests++;
      if ((gnt_a & gnt_b) !== 1'b0 || valid !== (gnt_a | gnt_b)) begin
        failed++;
        $display("FAIL %s invariant: got gnt_a=%b gnt_b=%b valid=%b, required exclusive grants and valid==gnt_a|gnt_b",
                 s.tag, gnt_a, gnt_b, valid);
      end
    end
  endtask

  // Drive one cycle of inputs, queue the expectation, check after the edge
  task automatic step(input logic r, input logic a, input logic b,
                      input logic [3:0] e, input string t);
    sb_t s;
    @(negedge clk);
    rst   = r;
    req_a = a;
    req_b = b;
    s.exp = e;
    s.tag = t;
    sb.push_back(s);
    @(posedge clk);
    #1;
    check_out();
  endtask

  // Both requesters held: A for 8, GAP, B for 8, GAP, repeating
  function automatic logic [3:0] both_exp(input int i);
    int p;
    if (FIXED) return OA;
    p = i % 18;
    if (p < 8)   return OA;
    if (p == 8)  return Z0;
    if (p < 17)  return OB;
    return Z1;
  endfunction

  initial begin
    rst   = 1'b1;
    req_a = 1'b0;
    req_b = 1'b0;

    // Reset with requests high, single requester, release to IDLE
    addv(1, 1, 1, Z0, "reset_cycle0");
    addv(1, 1, 1, Z0, "reset_cycle1");
    for (int i = 0; i < 5; i++) addv(0, 1, 0, OA, "a_only");
    addv(0, 0, 0, Z0, "a_release");
    addv(0, 0, 0, Z0, "idle_hold");
    // Tie from reset, release into GAP, handoff to B
    addv(1, 0, 0, Z0, "reset2");
    addv(0, 1, 1, OA, "tie_first_a");
    addv(0, 1, 1, OA, "a_hold1");
    addv(0, 1, 1, OA, "a_hold2");
    addv(0, 0, 1, Z0, "gap_sel0");
    addv(0, 0, 1, OB, "b_after_gap");
    addv(0, 0, 1, OB, "b_hold");
    addv(0, 0, 0, Z1, "idle_keeps_sel1");
    addv(0, 1, 0, OA, "a_from_idle");
    addv(0, 0, 1, Z0, "gap_again");
    addv(0, 0, 0, Z0, "drop_during_gap");
    addv(0, 1, 1, FIXED ? OA : OB, "tie_after_a");
    addv(0, 0, 0, FIXED ? Z0 : Z1, "idle_after_tie");

    foreach (vecs[k]) step(vecs[k].rst, vecs[k].ra, vecs[k].rb, vecs[k].exp, vecs[k].tag);

    // Both held: bounded hold with GAP between owners
    step(1, 0, 0, Z0, "reset_rr");
    for (int i = 0; i < 40; i++) step(0, 1, 1, both_exp(i), "both_held");
    step(0, 0, 1, Z0, "rr_a_release_gap");
    step(0, 0, 1, OB, "rr_b_granted");

    // Release on the same edge the hold limit is reached
    step(1, 0, 0, Z0, "reset_relpre");
    for (int i = 0; i < 8; i++) step(0, 1, 1, OA, "relpre_a_hold");
    step(0, 0, 1, Z0, "relpre_gap");
    step(0, 0, 1, OB, "relpre_b");

    // Lone requester is never preempted
    step(1, 0, 0, Z0, "reset_lone");
    for (int i = 0; i < 20; i++) step(0, 1, 0, OA, "a_alone_20");
    step(0, 0, 0, Z0, "a_alone_release");

    // Reset in the middle of B ownership
    step(1, 0, 0, Z0, "reset_midb");
    step(0, 0, 1, OB, "b_own1");
    step(0, 0, 1, OB, "b_own2");
    step(1, 1, 1, Z0, "reset_during_b");
    step(0, 1, 1, OA, "a_after_reset");
    step(0, 0, 0, Z0, "final_idle");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
